// File: rtl/adc_pkg.sv
// adc_pkg: shared widths, FSM state type and iqsel phase helper for the adc_r receive path.
// Latency: n/a (constants, types and a pure function only).
// Backpressure: n/a.
package adc_pkg;

  localparam int ADC_W    = 14;               // ADC word width
  localparam int SAMP_W   = 16;               // left-justified output sample width
  localparam int DC_SHIFT = 8;                // DC tracker leak shift
  localparam int ACC_W    = SAMP_W + DC_SHIFT; // 24-bit tracker accumulator
  localparam int ERR_W    = 8;                // sync error counter width

  typedef enum logic {
    HUNT   = 1'b0,
    LOCKED = 1'b1
  } adc_state_t;

  // I word is on the bus for phases 0-1, Q word for phases 2-3.
  function automatic logic exp_iqsel(input logic [1:0] ph);
    return (ph < 2'd2);
  endfunction

endpackage

// File: rtl/adc_r_if.sv
// adc_r_if: ADC capture bus plus deinterleaved sample output bundle; master = source/sink side, slave = adc_r.
// Latency: n/a (wires only). i_dc_est/q_dc_est exist only when ADC_DC_TRACK_EN is defined.
// Backpressure: none; the consumer must take every dav pulse.
interface adc_r_if;
  import adc_pkg::*;

  logic              adc_en;
  logic [ADC_W-1:0]  adc_d;
  logic              adc_iqsel;
  logic              calibrate;
  logic [SAMP_W-1:0] i_dc_cal;
  logic [SAMP_W-1:0] q_dc_cal;
  logic [SAMP_W-1:0] i_data;
  logic [SAMP_W-1:0] q_data;
  logic              dav;
  logic              locked;
  logic [ERR_W-1:0]  sync_errs;
`ifdef ADC_DC_TRACK_EN
  logic [SAMP_W-1:0] i_dc_est;
  logic [SAMP_W-1:0] q_dc_est;

  modport master (
    output adc_en, adc_d, adc_iqsel, calibrate, i_dc_cal, q_dc_cal,
    input  i_data, q_data, dav, locked, sync_errs, i_dc_est, q_dc_est
  );
  modport slave (
    input  adc_en, adc_d, adc_iqsel, calibrate, i_dc_cal, q_dc_cal,
    output i_data, q_data, dav, locked, sync_errs, i_dc_est, q_dc_est
  );
`else
  modport master (
    output adc_en, adc_d, adc_iqsel, calibrate, i_dc_cal, q_dc_cal,
    input  i_data, q_data, dav, locked, sync_errs
  );
  modport slave (
    input  adc_en, adc_d, adc_iqsel, calibrate, i_dc_cal, q_dc_cal,
    output i_data, q_data, dav, locked, sync_errs
  );
`endif

endinterface

// File: rtl/adc_dc_track.sv
// adc_dc_track: one-channel leaky-integrator DC estimator (est = acc >> DC_SHIFT), built only with ADC_DC_TRACK_EN.
// Latency: est_o reflects an update one clock after upd_i.
// Backpressure: none; updates on every upd_i strobe.
`ifdef ADC_DC_TRACK_EN
module adc_dc_track
  import adc_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              upd_i,
  input  logic [SAMP_W-1:0] raw_i,
  output logic [SAMP_W-1:0] est_o
);

  logic [ACC_W-1:0] acc_q;
  logic [ACC_W-1:0] acc_d;

  assign est_o = acc_q[ACC_W-1 -: SAMP_W];

  // Leak: add the new sample, subtract the current estimate (both sign-extended).
  always_comb begin
    acc_d = acc_q;
    if (upd_i) begin
      acc_d = acc_q + {{DC_SHIFT{raw_i[SAMP_W-1]}}, raw_i}
                    - {{DC_SHIFT{est_o[SAMP_W-1]}}, est_o};
    end
  end

  // Accumulator register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) acc_q <= '0;
    else     acc_q <= acc_d;
  end

endmodule
`endif

// File: rtl/adc_r.sv
// adc_r: locks to the ADC iqsel line, deinterleaves I/Q into 16-bit samples, subtracts offset (DC tracker with ADC_DC_TRACK_EN).
// Latency: pair registered at the ph=3 edge; dav pulses for one clock every 4 clocks while locked.
// Backpressure: none; a mismatch or adc_en drop returns to HUNT and drops the partial pair.
module adc_r
  import adc_pkg::*;
(
  input  logic    clk,
  input  logic    rst,
  adc_r_if.slave  bus
);

  adc_state_t        state_q, state_d;
  logic [1:0]        ph_q, ph_d;      // phase of the most recent accepted edge
  logic [1:0]        ph_cur;          // phase of the edge being evaluated now
  logic              iqsel_q;
  logic [ERR_W-1:0]  errs_q, errs_d;
  logic              cap_i;
  logic              fire;
  logic [SAMP_W-1:0] i_raw_q;
  logic [SAMP_W-1:0] q_word;
  logic [SAMP_W-1:0] off_i, off_q;
  logic [SAMP_W-1:0] i_data_q, q_data_q;
  logic              dav_q;

  assign ph_cur = ph_q + 2'd1;
  assign q_word = {bus.adc_d, {(SAMP_W-ADC_W){1'b0}}};

`ifdef ADC_DC_TRACK_EN
  logic [SAMP_W-1:0] i_est, q_est;
  logic              trk_upd;

  // Estimator freezes while calibrating.
  assign trk_upd = fire & ~bus.calibrate;

  adc_dc_track u_trk_i (
    .clk   (clk),
    .rst   (rst),
    .upd_i (trk_upd),
    .raw_i (i_raw_q),
    .est_o (i_est)
  );

  adc_dc_track u_trk_q (
    .clk   (clk),
    .rst   (rst),
    .upd_i (trk_upd),
    .raw_i (q_word),
    .est_o (q_est)
  );

  assign off_i        = bus.calibrate ? '0 : i_est;
  assign off_q        = bus.calibrate ? '0 : q_est;
  assign bus.i_dc_est = i_est;
  assign bus.q_dc_est = q_est;
`else
  assign off_i = bus.calibrate ? '0 : bus.i_dc_cal;
  assign off_q = bus.calibrate ? '0 : bus.q_dc_cal;
`endif

  // Next-state: lock on an enabled iqsel rising edge; mismatch beats a coincident edge.
  always_comb begin
    state_d = state_q;
    ph_d    = ph_q;
    errs_d  = errs_q;
    cap_i   = 1'b0;
    fire    = 1'b0;
    case (state_q)
      HUNT: begin
        if (bus.adc_en && bus.adc_iqsel && !iqsel_q) begin
          state_d = LOCKED;
          ph_d    = 2'd0;
        end
      end
      LOCKED: begin
        if (!bus.adc_en) begin
          state_d = HUNT;
        end else if (bus.adc_iqsel != exp_iqsel(ph_cur)) begin
          state_d = HUNT;
          if (errs_q != {ERR_W{1'b1}}) errs_d = errs_q + 1'b1;
        end else begin
          ph_d  = ph_cur;
          cap_i = (ph_cur == 2'd1);
          fire  = (ph_cur == 2'd3);
        end
      end
      default: state_d = HUNT;
    endcase
  end

  // FSM, phase, iqsel history and error counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= HUNT;
      ph_q    <= 2'd0;
      iqsel_q <= 1'b0;
      errs_q  <= '0;
    end else begin
      state_q <= state_d;
      ph_q    <= ph_d;
      iqsel_q <= bus.adc_iqsel;
      errs_q  <= errs_d;
    end
  end

  // Datapath: capture I at ph=1, finish the pair at ph=3; outputs hold otherwise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      i_raw_q  <= '0;
      i_data_q <= '0;
      q_data_q <= '0;
      dav_q    <= 1'b0;
    end else begin
      dav_q <= fire;
      if (cap_i) i_raw_q <= q_word;
      if (fire) begin
        i_data_q <= i_raw_q - off_i;
        q_data_q <= q_word - off_q;
      end
    end
  end

  assign bus.i_data    = i_data_q;
  assign bus.q_data    = q_data_q;
  assign bus.dav       = dav_q;
  assign bus.locked    = (state_q == LOCKED);
  assign bus.sync_errs = errs_q;

endmodule

// File: doc/adc_r.md
# adc_r

Receive-side counterpart of the IQ DAC driver. It captures the interleaved I/Q word stream from the dual-channel ADC on the 4x-sample-rate clock and locks to the ADC's IQ-select line. It deinterleaves each I/Q pair into left-justified 16-bit two's-complement samples, removes DC offset and presents one sample pair per four clocks with a single-cycle valid pulse to the demodulator.

## Interface
Parameters (fixed constants from `adc_pkg`; no module parameters):
- `ADC_W`, 14, ADC word width
- `SAMP_W`, 16, output sample width
- `DC_SHIFT`, 8, DC tracker leak shift (log2 time constant in sample pairs)

Ports:
- `clk`  in  1  4x sample-rate clock, all logic on posedge
- `rst`  in  1  asynchronous, active-high reset
- `adc_en`  in  1  capture enable; low forces HUNT
- `adc_d`  in  14  ADC data word, two's complement
- `adc_iqsel`  in  1  high = I word on bus, low = Q word; each phase lasts 2 clocks
- `calibrate`  in  1  high = bypass offset removal, output raw samples
- `i_dc_cal`, `q_dc_cal`  in  16  static offsets subtracted per channel
- `i_data`, `q_data`  out  16  deinterleaved samples
- `dav`  out  1  one-cycle pulse, new pair on `i_data`/`q_data`
- `locked`  out  1  high in LOCKED state
- `sync_errs`  out  8  saturating count of lock losses
- `i_dc_est`, `q_dc_est`  out  16  DC estimates (present only with `ADC_DC_TRACK_EN`)

## Operation
- Two-state FSM, HUNT and LOCKED, with a 2-bit phase counter `ph`. `adc_iqsel` is registered one cycle (`iqsel_q`) for edge detection.
- HUNT: on a clock where `adc_en`=1, `adc_iqsel`=1 and `iqsel_q`=0 (rising edge), set `ph`=0 and go to LOCKED. That clock counts as the first I clock.
- LOCKED: `ph` increments modulo 4 every clock. Expected `adc_iqsel` = 1 for `ph` 0–1 and 0 for `ph` 2–3.
  - `ph`=1: `i_raw <= {adc_d,2'b00}`.
  - `ph`=3: compute and register the outputs, and pulse `dav`.
- Mismatch of `adc_iqsel` against the expected value in LOCKED:
  - go to HUNT and discard the partial pair (no `dav`);
  - `sync_errs` increments, saturating at 255.
- `adc_en`=0 in any state: go to HUNT next clock. There is no `dav` and no error count for this exit.
- Output arithmetic, modulo 2^16 (wraps, no saturation):
  - `i_data = i_raw - off_i`
  - `q_data = {adc_d,2'b00} - off_q`
  - With `calibrate`=1: `off_i` = `off_q` = 0.
  - With `calibrate`=0: `off_i`/`off_q` = `i_dc_cal`/`q_dc_cal`.
- Outputs hold their last value between `dav` pulses and across loss of lock.

## Timing
- Reset values:
  - state HUNT, `ph`=0, `iqsel_q`=0;
  - `i_data`=`q_data`=0, `dav`=0, `locked`=0, `sync_errs`=0;
  - `i_raw`=0, DC accumulators 0.
- Latency: Q word sampled at the `ph`=3 edge. `i_data`, `q_data` and `dav` are valid immediately after that edge, i.e. during the next frame's `ph`=0 cycle.
- `dav` period is exactly 4 clocks while locked. First `dav` comes 4 clocks after the locking edge.
- `locked` is registered and asserts the clock after the lock edge. It deasserts the clock after a mismatch or after `adc_en` falls.
- Mismatch and rising edge in the same clock: the mismatch is handled first. The FSM is in HUNT for at least one clock, then may relock on a later rising edge.
- A mismatch at `ph`=3 suppresses that `dav`.
- `rst` mid-frame: immediate return to reset values. No `dav` is generated until relock.

## Configuration
- `ADC_DC_TRACK_EN` defined: adds a per-channel leaky-integrator DC tracker.
  - 24-bit signed `acc`; `est = acc[23:8]`.
  - On each `dav`, with `calibrate`=0: `acc <= acc + sext(raw) - sext(est)`.
  - With `calibrate`=0, `off = est` (static `*_dc_cal` ignored). With `calibrate`=1, the estimator is frozen and `off`=0.
  - `i_dc_est`/`q_dc_est` ports are present.
- `ADC_DC_TRACK_EN` undefined: static offset only. No tracker logic and no `*_dc_est` ports.

## Structure
- `adc_pkg`:
  - `ADC_W`, `SAMP_W`, `DC_SHIFT`, `ACC_W`=24;
  - typedef `adc_state_t` {HUNT, LOCKED};
  - function for expected iqsel from `ph`.
- Sub-module `adc_dc_track`: one accumulator/estimate channel, instantiated twice under `ADC_DC_TRACK_EN`.

## Test plan
- Clean stream: iqsel pattern 1100 repeating, I=14'h0100, Q=14'h3F00, cal 0, `calibrate`=0.
  - Expected: lock on the first rising edge; `dav` every 4 clocks starting 4 clocks after lock; `i_data`=16'h0400, `q_data`=16'hFC00.
- Static offset: `i_dc_cal`=16'h0010, I=14'h0000.
  - Expected: `i_data`=16'hFFF0 (wrap).
  - With `calibrate`=1, expected `i_data`=16'h0000.
- Sync loss: force iqsel=0 at `ph`=1.
  - Expected: `locked` drops the next clock; no `dav` for that frame; `sync_errs`=1; relock on the next rising edge.
  - 300 forced losses → `sync_errs` saturates at 255.
- `adc_en` falls mid-frame.
  - Expected: HUNT, no `dav`, `sync_errs` unchanged; re-enable → relock.
- `rst` pulse at `ph`=2 while locked.
  - Expected: all outputs 0 immediately; first `dav` 4 clocks after the next lock edge.
- `ADC_DC_TRACK_EN` build: constant I=14'h0040 (raw 16'h0100).
  - Expected: `i_dc_est` converges monotonically to 16'h0100 ±1 within 4096 pairs; `i_data` settles at 16'h0000 ±1.
